// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the phase encoding used by both the
// horizontal and vertical sequencers.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_e;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous active-low reset to a
// configurable idle value; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA source timing: pixel/line counters with phase FSMs, sync/blank decode
// delayed to match the pixel source, and a blanked RGB output register.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_req,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic [7:0] R_dac,
  output logic [7:0] G_dac,
  output logic [7:0] B_dac
);

  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SY_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SY_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       run_q, run_d;
  phase_e     h_q, h_d, v_q, v_d;
  logic       line_end;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      run_q <= 1'b0;
      h_q   <= ACTIVE;
      v_q   <= ACTIVE;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      run_q <= run_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // run_q holds the counters at 0 for the first enabled clock so x=0,y=0 is presented once
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    h_d      = h_q;
    v_d      = v_q;
    run_d    = enable;
    line_end = (x_q == H_LAST);
    if (!enable) begin
      x_d = '0;
      y_d = '0;
      h_d = ACTIVE;
      v_d = ACTIVE;
    end else if (run_q) begin
      x_d = line_end ? '0 : x_q + 10'd1;
      unique case (h_q)
        ACTIVE: if (x_q == H_ACT_END) h_d = FRONT;
        FRONT:  if (x_q == H_FP_END)  h_d = SYNC;
        SYNC:   if (x_q == H_SY_END)  h_d = BACK;
        BACK:   if (line_end)         h_d = ACTIVE;
      endcase
      if (line_end) begin
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        unique case (v_q)
          ACTIVE: if (y_q == V_ACT_END) v_d = FRONT;
          FRONT:  if (y_q == V_FP_END)  v_d = SYNC;
          SYNC:   if (y_q == V_SY_END)  v_d = BACK;
          BACK:   if (y_q == V_LAST)    v_d = ACTIVE;
        endcase
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_req     = run_q && (h_q == ACTIVE) && (v_q == ACTIVE);
  assign line_start  = run_q && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);

  logic [2:0] raw, dly;
  assign raw = {h_q != SYNC, v_q != SYNC, pix_req};

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (3'b110)
  ) u_dly (
    .clk_i  (pixel_clk),
    .rst_ni (reset_n),
    .d_i    (raw),
    .q_o    (dly)
  );

  logic       hs_q, vs_q, blank_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= dly[2];
      vs_q    <= dly[1];
      blank_q <= dly[0];
      r_q     <= dly[0] ? R_in : '0;
      g_q     <= dly[0] ? G_in : '0;
      b_q     <= dly[0] ? B_in : '0;
    end
  end

  assign hsync_n = hs_q;
  assign vsync_n = vs_q;
  assign blank_n = blank_q;
  assign R_dac   = r_q;
  assign G_dac   = g_q;
  assign B_dac   = b_q;

endmodule
